ddc_pulse_ctrl: RTL
===================

# ddc_pulse_ctrl

Capture sequencer for the digital down-converter. Waits out the FIR pipeline fill after reset, then, per radar PRT trigger, waits a programmable range-gate delay, decimates the full-rate baseband I/Q stream by DECIM, and delivers exactly num_samp sample pairs to the downstream buffer over a valid/ready interface through a 2-entry FIFO. It replaces free-running decimation with pulse-aligned, flow-controlled capture.

## Interface
- WIDTH, 12, I/Q sample width (two's complement)
- DECIM, 16, decimation ratio (≥2)
- SETTLE, 64, post-reset cycles before triggers are accepted (FIR fill)
- CNT_W, 16, width of delay/count fields

- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-low reset
- trig  in  1  PRT trigger, single-cycle pulse
- delay  in  CNT_W  range-gate delay in clk cycles, sampled on accepted trig
- num_samp  in  CNT_W  sample pairs per pulse, sampled on accepted trig
- din_i, din_q  in  WIDTH  full-rate filtered baseband I/Q
- dout_i, dout_q  out  WIDTH  FIFO head I/Q
- dout_valid  out  1  FIFO non-empty
- dout_ready  in  1  downstream accepts head this cycle
- dout_last  out  1  head is last sample of the pulse
- busy  out  1  high in WAIT, CAPTURE, DRAIN
- done  out  1  one-cycle pulse at end of pulse
- overflow  out  1  sticky: a sample was dropped

## Operation
- States: FLUSH, IDLE, WAIT, CAPTURE, DRAIN.
- FLUSH: entered on reset; counts SETTLE edges then IDLE. trig ignored.
- IDLE: trig=1 → latch delay (D), num_samp (N); clear overflow. N=0 → stay IDLE, pulse done next cycle. N>0: D=0 → CAPTURE, else WAIT.
- WAIT: counts D edges, then CAPTURE.
- CAPTURE: phase counter (0..DECIM-1) restarts at 0 on entry; on every edge with phase=0 push {din_i, din_q, last} into FIFO, last=1 for sample N-1. After the N-th push → DRAIN.
- DRAIN: when FIFO empty → IDLE, pulse done.
- trig outside IDLE ignored (no queueing, no flag).
- FIFO: 2 entries, first-word-fall-through. Pop on dout_valid & dout_ready. Push when full without simultaneous pop: sample dropped, overflow set, sample still counted (N pushes attempted total; if last is dropped, no dout_last appears). Push and pop same cycle while full: both succeed, no overflow.
- Data passed unmodified (no rounding/scaling); width WIDTH in and out.
- Sample counter and phase counter are CNT_W and ceil(log2 DECIM) bits; N up to 2^CNT_W-1, D up to 2^CNT_W-1.

## Timing
- Reset values: dout_i=dout_q=0, dout_valid=0, dout_last=0, busy=0, done=0, overflow=0, FIFO empty, state FLUSH.
- Reset mid-pulse: immediate abort, FIFO flushed, re-enter FLUSH; no done.
- Earliest accepted trig: edge SETTLE+1 after rst deasserts (first SETTLE edges are FLUSH).
- trig sampled at edge E0: busy high after E0. Sample k (0..N-1) is din at edge E(1+D+k·DECIM); dout_valid high after that edge if FIFO was empty (latency 1 cycle from sampling edge).
- Last push at E(1+D+(N-1)·DECIM); with dout_ready held high, done is high for the cycle after the edge that pops the last entry; busy drops in that same cycle.
- done and busy never high together. dout_last asserted only with dout_valid.
- dout_* hold stable while dout_valid=1 and dout_ready=0.

## Test plan
- Reset/flush: rst low→high, trig every cycle for 70 cycles, SETTLE=64 → first trig accepted at edge 65; all outputs 0 during reset.
- Basic pulse: D=5, N=4, DECIM=16, ready=1, din_i=cycle count → dout_i = values at E6, E22, E38, E54; dout_last on 4th; done one cycle after 4th pop; overflow=0.
- Zero cases: N=0 → done pulse next cycle, busy never high; D=0, N=1 → sample taken at E1, valid after E1.
- Backpressure: ready=0 throughout, N=4 → first 2 samples held stable, samples 3–4 dropped, overflow=1, no dout_last; raise ready → 2 samples drained, done; next trig clears overflow.
- Full push/pop: DECIM=2, ready toggling 1-0 with FIFO full on push cycles where ready=1 → no overflow, all N samples delivered in order.
- Trig during busy ignored, and rst asserted mid-CAPTURE → dout_valid=0 immediately, no done, FLUSH restarts.

Source files
------------

// File: rtl/ddc_pulse_ctrl.sv
// rtl/ddc_pulse_ctrl.sv - pulse-aligned DDC capture sequencer with 2-entry output FIFO
module ddc_pulse_ctrl #(
    parameter int WIDTH  = 12,
    parameter int DECIM  = 16,
    parameter int SETTLE = 64,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trig,
    input  logic [CNT_W-1:0] delay,
    input  logic [CNT_W-1:0] num_samp,
    input  logic [WIDTH-1:0] din_i,
    input  logic [WIDTH-1:0] din_q,
    output logic [WIDTH-1:0] dout_i,
    output logic [WIDTH-1:0] dout_q,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             dout_last,
    output logic             busy,
    output logic             done,
    output logic             overflow
);
    localparam int PH_W = $clog2(DECIM);
    localparam int FL_W = $clog2(SETTLE + 1);

    typedef enum logic [2:0] {FLUSH, IDLE, WAIT, CAPTURE, DRAIN} state_t;

    state_t           state;
    logic [FL_W-1:0]  flush_cnt;
    logic [CNT_W-1:0] d_lat;
    logic [CNT_W-1:0] n_lat;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] samp_cnt;
    logic [PH_W-1:0]  phase;
    logic [WIDTH-1:0] tail_i;
    logic [WIDTH-1:0] tail_q;
    logic             tail_last;
    logic [1:0]       count;
    logic             push;
    logic             pop;
    logic             push_last;

    assign dout_valid = (count != 2'd0);
    assign pop        = dout_valid & dout_ready;
    assign push       = (state == CAPTURE) && (phase == '0);
    assign push_last  = (samp_cnt == n_lat - CNT_W'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= FLUSH;
            flush_cnt <= '0;
            d_lat     <= '0;
            n_lat     <= '0;
            wait_cnt  <= '0;
            samp_cnt  <= '0;
            phase     <= '0;
            dout_i    <= '0;
            dout_q    <= '0;
            dout_last <= 1'b0;
            tail_i    <= '0;
            tail_q    <= '0;
            tail_last <= 1'b0;
            count     <= 2'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            done <= 1'b0;

            // Head registers drive dout_* directly, so they only move on pop or fill-from-empty.
            case (count)
                2'd0: begin
                    if (push) begin
                        dout_i    <= din_i;
                        dout_q    <= din_q;
                        dout_last <= push_last;
                        count     <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        dout_i    <= din_i;
                        dout_q    <= din_q;
                        dout_last <= push_last;
                    end else if (push) begin
                        tail_i    <= din_i;
                        tail_q    <= din_q;
                        tail_last <= push_last;
                        count     <= 2'd2;
                    end else if (pop) begin
                        dout_last <= 1'b0;
                        count     <= 2'd0;
                    end
                end
                default: begin
                    if (pop) begin
                        dout_i    <= tail_i;
                        dout_q    <= tail_q;
                        dout_last <= tail_last;
                        if (push) begin
                            tail_i    <= din_i;
                            tail_q    <= din_q;
                            tail_last <= push_last;
                        end else begin
                            count <= 2'd1;
                        end
                    end else if (push) begin
                        overflow <= 1'b1;
                    end
                end
            endcase

            case (state)
                FLUSH: begin
                    if (flush_cnt == FL_W'(SETTLE - 1)) state <= IDLE;
                    else flush_cnt <= flush_cnt + FL_W'(1);
                end
                IDLE: begin
                    if (trig) begin
                        d_lat    <= delay;
                        n_lat    <= num_samp;
                        overflow <= 1'b0;
                        wait_cnt <= '0;
                        samp_cnt <= '0;
                        phase    <= '0;
                        if (num_samp == '0) begin
                            done <= 1'b1;
                        end else begin
                            busy  <= 1'b1;
                            state <= (delay == '0) ? CAPTURE : WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (wait_cnt == d_lat - CNT_W'(1)) state <= CAPTURE;
                    else wait_cnt <= wait_cnt + CNT_W'(1);
                end
                CAPTURE: begin
                    phase <= (phase == PH_W'(DECIM - 1)) ? '0 : phase + PH_W'(1);
                    if (push) begin
                        samp_cnt <= samp_cnt + CNT_W'(1);
                        if (push_last) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Leave as the last entry pops so done lines up with the empty FIFO.
                    if (count == 2'd0 || (count == 2'd1 && pop)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= FLUSH;
            endcase
        end
    end
endmodule
